// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//
// Purpose : Shared definitions for the GPIO block family. It holds the default
//           pin count, the default debounce counter width and the synchronizer
//           depth, plus the register offsets used by the GPIO control IP.
//           The input filter imports this package for its parameter defaults.
//
// Contents:
//   GPIO_WIDTH_DEF   default number of pins (8)
//   DEBOUNCE_W_DEF   default debounce counter / limit width (16)
//   SYNC_STAGES_DEF  default synchronizer depth (2)
//   GPIO_OFS_*       register offsets DATA=0, DIR=1, READ=2
//   gpio_reg_e       the same offsets as an enumerated type
// -----------------------------------------------------------------------------
package gpio_pkg;

  localparam int GPIO_WIDTH_DEF  = 8;
  localparam int DEBOUNCE_W_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Register map of the GPIO control IP that consumes gpio_in_o.
  localparam logic [1:0] GPIO_OFS_DATA = 2'd0;
  localparam logic [1:0] GPIO_OFS_DIR  = 2'd1;
  localparam logic [1:0] GPIO_OFS_READ = 2'd2;

  typedef enum logic [1:0] {
    GPIO_REG_DATA = 2'd0,
    GPIO_REG_DIR  = 2'd1,
    GPIO_REG_READ = 2'd2
  } gpio_reg_e;

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
//
// Purpose : One pin's synchronizer and debounce filter. The raw pad level goes
//           through a SYNC_STAGES-deep flop chain. The synchronized level is
//           accepted as the new stable level only after it has differed from
//           the current stable level for more than 'limit' consecutive cycles.
//           A registered one-cycle rise or fall pulse is emitted in the same
//           cycle that the new stable level appears on 'level'.
//
// Ports   :
//   clk         in   block clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pad         in   raw asynchronous pad level
//   limit       in   [DEBOUNCE_W] stable cycles required (quasi-static)
//   level       out  filtered (stable) level, registered
//   rise_pulse  out  one-cycle pulse on an accepted 0->1 change
//   fall_pulse  out  one-cycle pulse on an accepted 1->0 change
// -----------------------------------------------------------------------------
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_W  = DEBOUNCE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pad,
  input  logic [DEBOUNCE_W-1:0] limit,
  output logic                  level,
  output logic                  rise_pulse,
  output logic                  fall_pulse
);

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_bit;

  logic [DEBOUNCE_W-1:0]  cnt_reg;
  logic [DEBOUNCE_W-1:0]  cnt_next;
  logic                   stable_reg;
  logic                   stable_next;
  logic                   rise_reg;
  logic                   rise_next;
  logic                   fall_reg;
  logic                   fall_next;

  logic                   differs;
  logic                   accept;

  // Synchronizer chain: bit 0 samples the pad, the top bit is the
  // metastability-safe level used by the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad};
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  // The compare is >= so that lowering the limit below a running count
  // accepts the pending change on the very next cycle.
  assign differs = sync_bit ^ stable_reg;
  assign accept  = differs && (cnt_reg >= limit);

  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;

    if (!differs) begin
      // Input agrees with the accepted level: any partial count (glitch)
      // is discarded.
      cnt_next = '0;
    end else if (accept) begin
      stable_next = sync_bit;
      cnt_next    = '0;
      rise_next   = sync_bit;
      fall_next   = ~sync_bit;
    end else if (!(&cnt_reg)) begin
      // Saturate at all-ones so a very long pending change never wraps.
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign level      = stable_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule : gpio_debounce_bit

// File: rtl/gpio_input_filter.sv
// -----------------------------------------------------------------------------
// gpio_input_filter
//
// Purpose : Per-pin synchronizer, debounce filter and edge detector for the
//           GPIO input path, with optional sticky edge-interrupt flags.
//           The filtered levels drive gpio_in of the GPIO control IP.
//
// Build option:
//   GPIO_FILTER_IRQ_EN  defined   -> per-pin sticky irq_status flags set by
//                                    enabled rise/fall pulses, cleared by
//                                    irq_clear (set wins), irq_o = OR of them.
//                       undefined -> irq_status and irq_o are tied to 0 and the
//                                    enable / clear inputs are ignored.
//
// Ports   :
//   clk             in   block clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   pad_in          in   [GPIO_WIDTH] raw asynchronous pad levels
//   debounce_limit  in   [DEBOUNCE_W] stable cycles required (quasi-static)
//   irq_rise_en     in   [GPIO_WIDTH] rising-edge interrupt enables
//   irq_fall_en     in   [GPIO_WIDTH] falling-edge interrupt enables
//   irq_clear       in   [GPIO_WIDTH] one-cycle clear strobes for irq_status
//   gpio_in_o       out  [GPIO_WIDTH] filtered levels, registered
//   rise_pulse      out  [GPIO_WIDTH] accepted 0->1 change pulses
//   fall_pulse      out  [GPIO_WIDTH] accepted 1->0 change pulses
//   irq_status      out  [GPIO_WIDTH] sticky pending flags
//   irq_o           out  OR-reduction of irq_status
// -----------------------------------------------------------------------------
module gpio_input_filter
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_W  = DEBOUNCE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GPIO_WIDTH-1:0] pad_in,
  input  logic [DEBOUNCE_W-1:0] debounce_limit,
  input  logic [GPIO_WIDTH-1:0] irq_rise_en,
  input  logic [GPIO_WIDTH-1:0] irq_fall_en,
  input  logic [GPIO_WIDTH-1:0] irq_clear,
  output logic [GPIO_WIDTH-1:0] gpio_in_o,
  output logic [GPIO_WIDTH-1:0] rise_pulse,
  output logic [GPIO_WIDTH-1:0] fall_pulse,
  output logic [GPIO_WIDTH-1:0] irq_status,
  output logic                  irq_o
);

  // ---------------------------------------------------------------------------
  // Per-pin filter instances
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pin
      gpio_debounce_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad        (pad_in[gi]),
        .limit      (debounce_limit),
        .level      (gpio_in_o[gi]),
        .rise_pulse (rise_pulse[gi]),
        .fall_pulse (fall_pulse[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge interrupt flags
  // ---------------------------------------------------------------------------
`ifdef GPIO_FILTER_IRQ_EN

  logic [GPIO_WIDTH-1:0] irq_status_reg;
  logic [GPIO_WIDTH-1:0] irq_status_next;
  logic [GPIO_WIDTH-1:0] irq_set;

  assign irq_set = (rise_pulse & irq_rise_en) | (fall_pulse & irq_fall_en);

  // Set has priority over clear so an edge arriving with the clear strobe is
  // never lost. Changing an enable only gates new sets; pending flags stay.
  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_irq
      always_comb begin
        irq_status_next[gi] = irq_status_reg[gi];
        if (irq_set[gi]) begin
          irq_status_next[gi] = 1'b1;
        end else if (irq_clear[gi]) begin
          irq_status_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status_reg <= '0;
    end else begin
      irq_status_reg <= irq_status_next;
    end
  end

  assign irq_status = irq_status_reg;
  assign irq_o      = |irq_status_reg;

`else

  // Interrupt logic is compiled out; the control inputs are intentionally
  // left without a load.
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_rise_en, irq_fall_en, irq_clear};

  assign irq_status = '0;
  assign irq_o      = 1'b0;

`endif

endmodule : gpio_input_filter

// File: tb/tb_gpio_input_filter.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_filter
//
// Scoreboard bench for gpio_input_filter. Each held pad change pushes the
// expected pulse (cycle, pin, direction) onto a queue; a monitor on the
// falling clock edge pops and compares every pulse the DUT emits, and flags
// expected pulses whose cycle has passed without appearing.
// -----------------------------------------------------------------------------
module tb_gpio_input_filter;

  localparam int W  = 8;
  localparam int DW = 16;
  localparam int SS = 2;

`ifdef GPIO_FILTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pad_in;
  logic [DW-1:0] debounce_limit;
  logic [W-1:0]  irq_rise_en;
  logic [W-1:0]  irq_fall_en;
  logic [W-1:0]  irq_clear;
  logic [W-1:0]  gpio_in_o;
  logic [W-1:0]  rise_pulse;
  logic [W-1:0]  fall_pulse;
  logic [W-1:0]  irq_status;
  logic          irq_o;

  gpio_input_filter #(
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (SS),
    .DEBOUNCE_W  (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_in         (pad_in),
    .debounce_limit (debounce_limit),
    .irq_rise_en    (irq_rise_en),
    .irq_fall_en    (irq_fall_en),
    .irq_clear      (irq_clear),
    .gpio_in_o      (gpio_in_o),
    .rise_pulse     (rise_pulse),
    .fall_pulse     (fall_pulse),
    .irq_status     (irq_status),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int pin;
    bit rise;
  } exp_t;

  exp_t sb_q[$];

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cur_limit  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new pad vector that will be held; expected pulses are queued for
  // every changed pin at capture edge + synchronizer depth + limit.
  task automatic set_pad(input logic [W-1:0] v);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      if (v[i] != pad_in[i]) begin
        e.cyc  = cyc + 1 + SS + cur_limit;
        e.pin  = i;
        e.rise = v[i];
        sb_q.push_back(e);
      end
    end
    pad_in = v;
  endtask

  task automatic push_exp(input int c, input int p, input bit r);
    exp_t e;
    e.cyc  = c;
    e.pin  = p;
    e.rise = r;
    sb_q.push_back(e);
  endtask

  // Monitor: one line per observed pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check_eq("missed_pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
      for (int i = 0; i < W; i++) begin
        if (rise_pulse[i] || fall_pulse[i]) begin
          $display("pulse cyc=%0d pin=%0d rise=%0b fall=%0b level=%0b",
                   cyc, i, rise_pulse[i], fall_pulse[i], gpio_in_o[i]);
          if (sb_q.size() == 0) begin
            check_eq("unexpected_pulse_pin", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
            check_eq("pulse_pin", 32'(i), 32'(e.pin));
            check_eq("pulse_rise", 32'(rise_pulse[i]), 32'(e.rise));
            check_eq("pulse_fall", 32'(fall_pulse[i]), 32'(!e.rise));
            check_eq("pulse_level", 32'(gpio_in_o[i]), 32'(e.rise));
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rst_n          = 1'b0;
    pad_in         = '0;
    debounce_limit = '0;
    irq_rise_en    = '0;
    irq_fall_en    = '0;
    irq_clear      = '0;

    // Reset state
    wait_cyc(3);
    check_eq("rst_gpio_in", 32'(gpio_in_o), 32'h0);
    check_eq("rst_rise", 32'(rise_pulse), 32'h0);
    check_eq("rst_fall", 32'(fall_pulse), 32'h0);
    check_eq("rst_irq_status", 32'(irq_status), 32'h0);
    check_eq("rst_irq_o", 32'(irq_o), 32'h0);
    rst_n = 1'b1;
    wait_cyc(3);

    // limit=0: pin 0 rise then fall, latency SYNC_STAGES+1
    cur_limit = 0;
    debounce_limit = 16'd0;
    set_pad(8'h01);
    wait_cyc(6);
    check_eq("lim0_level_hi", 32'(gpio_in_o[0]), 32'h1);
    set_pad(8'h00);
    wait_cyc(6);
    check_eq("lim0_level_lo", 32'(gpio_in_o[0]), 32'h0);

    // limit=4: 1-cycle glitches on pin 1 every 3 cycles must be rejected
    cur_limit = 4;
    debounce_limit = 16'd4;
    for (int k = 0; k < 8; k++) begin
      pad_in[1] = 1'b1;
      wait_cyc(1);
      pad_in[1] = 1'b0;
      wait_cyc(2);
    end
    wait_cyc(8);
    check_eq("glitch_level", 32'(gpio_in_o[1]), 32'h0);

    // Boundary: a 4-cycle pulse on pin 3 is one short of acceptance
    pad_in[3] = 1'b1;
    wait_cyc(4);
    pad_in[3] = 1'b0;
    wait_cyc(10);
    check_eq("short_pulse_level", 32'(gpio_in_o[3]), 32'h0);
    set_pad(pad_in | 8'h08);
    wait_cyc(10);
    check_eq("held_level_pin3", 32'(gpio_in_o[3]), 32'h1);

    // Falling-edge interrupt on pin 2
    set_pad(pad_in | 8'h04);
    wait_cyc(10);
    check_eq("irq_none_on_rise", 32'(irq_status), 32'h0);
    irq_fall_en = 8'h04;
    set_pad(pad_in & ~8'h04);
    wait_cyc(7);
    check_eq("irq_not_yet", 32'(irq_status), 32'h0);
    wait_cyc(1);
    check_eq("irq_status_fall", 32'(irq_status), IRQ_ON ? 32'h04 : 32'h0);
    check_eq("irq_o_fall", 32'(irq_o), IRQ_ON ? 32'h1 : 32'h0);

    // Disabling the enable keeps the pending flag
    irq_fall_en = 8'h00;
    wait_cyc(3);
    check_eq("irq_kept_after_disable", 32'(irq_status), IRQ_ON ? 32'h04 : 32'h0);

    // Clear coincident with a new enabled rise on pin 2: set wins
    irq_rise_en = 8'h04;
    set_pad(pad_in | 8'h04);
    wait_cyc(7);
    irq_clear = 8'h04;
    wait_cyc(1);
    check_eq("irq_set_wins", 32'(irq_status), IRQ_ON ? 32'h04 : 32'h0);
    wait_cyc(1);
    irq_clear = 8'h00;
    check_eq("irq_cleared", 32'(irq_status), 32'h0);
    check_eq("irq_o_cleared", 32'(irq_o), 32'h0);
    irq_rise_en = 8'h00;

    // Lowering the limit below a running count accepts next cycle
    cur_limit = 20;
    debounce_limit = 16'd20;
    pad_in[4] = 1'b1;
    wait_cyc(10);
    check_eq("pre_lower_level", 32'(gpio_in_o[4]), 32'h0);
    debounce_limit = 16'd2;
    push_exp(cyc + 1, 4, 1'b1);
    wait_cyc(3);
    check_eq("lowered_limit_level", 32'(gpio_in_o[4]), 32'h1);

    // Return all pins low
    cur_limit = 0;
    debounce_limit = 16'd0;
    set_pad(8'h00);
    wait_cyc(8);
    check_eq("all_low", 32'(gpio_in_o), 32'h0);

    // Reset mid-debounce with pin 5 held high, limit=100
    cur_limit = 100;
    debounce_limit = 16'd100;
    pad_in[5] = 1'b1;
    wait_cyc(52);
    rst_n = 1'b0;
    wait_cyc(1);
    check_eq("midrst_gpio_in", 32'(gpio_in_o), 32'h0);
    check_eq("midrst_irq", 32'(irq_status), 32'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    t0 = cyc;
    push_exp(t0 + 103, 5, 1'b1);
    wait_cyc(100);
    check_eq("no_early_level", 32'(gpio_in_o[5]), 32'h0);
    wait_cyc(10);
    check_eq("post_rst_level", 32'(gpio_in_o[5]), 32'h1);

    wait_cyc(5);
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_gpio_input_filter

// File: doc/gpio_input_filter.md
GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

Interface
REQ-001 Parameter GPIO_WIDTH, default 8: number of pins, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth, minimum 2.
REQ-003 Parameter DEBOUNCE_W, default 16: debounce counter and limit width.
REQ-004 clk  input  1  block clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pad_in  input  GPIO_WIDTH  raw asynchronous pad levels.
REQ-007 debounce_limit  input  DEBOUNCE_W  stable cycles required before accepting a change; quasi-static.
REQ-008 irq_rise_en  input  GPIO_WIDTH  per-pin rising-edge interrupt enable.
REQ-009 irq_fall_en  input  GPIO_WIDTH  per-pin falling-edge interrupt enable.
REQ-010 irq_clear  input  GPIO_WIDTH  per-pin one-cycle clear strobe for irq_status (W1C source).
REQ-011 gpio_in_o  output  GPIO_WIDTH  filtered levels; drives gpio_in of the GPIO control IP.
REQ-012 rise_pulse  output  GPIO_WIDTH  one-cycle pulse per accepted 0->1 change.
REQ-013 fall_pulse  output  GPIO_WIDTH  one-cycle pulse per accepted 1->0 change.
REQ-014 irq_status  output  GPIO_WIDTH  sticky per-pin pending flags.
REQ-015 irq_o  output  1  OR-reduction of irq_status.

Function
REQ-016 Each pad bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-017 Per pin, a counter cnt[i] SHALL clear when sync[i]==stable[i], else increment by 1 per cycle.
REQ-018 When sync[i]!=stable[i] and cnt[i]>=debounce_limit, stable[i] SHALL take sync[i] next cycle and cnt[i] SHALL clear.
REQ-019 cnt[i] SHALL saturate at all-ones and never wrap.
REQ-020 A glitch that returns to stable[i] before the limit is reached SHALL clear cnt[i] and not change stable[i].
REQ-021 debounce_limit=0 SHALL give latency SYNC_STAGES+1 cycles from pad_in to gpio_in_o; in general SYNC_STAGES+limit+1 cycles.
REQ-022 Lowering debounce_limit below a running cnt[i] SHALL accept the change on the next cycle (>= compare).
REQ-023 gpio_in_o SHALL equal stable, registered, with no combinational path from pad_in.
REQ-024 rise_pulse[i]/fall_pulse[i] SHALL assert in the same cycle gpio_in_o[i] shows its new value, for exactly one cycle.
REQ-025 irq_status[i] SHALL set on (rise_pulse[i]&irq_rise_en[i]) | (fall_pulse[i]&irq_fall_en[i]), registered one cycle after the pulse.
REQ-026 irq_clear[i] SHALL clear irq_status[i] next cycle; a simultaneous set and clear SHALL leave the flag set.
REQ-027 Disabling an enable SHALL NOT clear an already pending flag.
REQ-028 irq_o SHALL be the combinational OR of irq_status.

Reset
REQ-029 rst_n low SHALL immediately zero all sync flops, cnt, stable, irq_status; all outputs 0.
REQ-030 A pad held high through reset SHALL produce one accepted rising change after reset release, per REQ-018.
REQ-031 Reset mid-debounce SHALL discard the partial count; no pulse is emitted for it.

Configuration
REQ-032 Macro GPIO_FILTER_IRQ_EN defined: REQ-025..REQ-028 are implemented.
REQ-033 Macro GPIO_FILTER_IRQ_EN undefined: irq_status and irq_o tied 0, no status flops, irq_*_en and irq_clear ignored; rise_pulse/fall_pulse and filtering unchanged.

Structure
REQ-034 Shared package gpio_pkg SHALL hold GPIO_WIDTH and DEBOUNCE_W defaults and the register-offset constants (DATA=0, DIR=1, READ=2).
REQ-035 Per-pin synchronizer plus debounce SHALL be sub-module gpio_debounce_bit, instantiated GPIO_WIDTH times by generate.

Verification
REQ-036 limit=0, pad[0] 0->1 at cycle 10 -> gpio_in_o[0]=1 and rise_pulse[0] high at cycle 13 only.
REQ-037 limit=4, pad[1] 1-cycle high glitches every 3 cycles -> gpio_in_o[1] stays 0, no pulses.
REQ-038 limit=4, irq_fall_en=0x04, pad[2] 1->0 held -> fall_pulse[2] after 7 cycles, irq_status=0x04, irq_o=1 next cycle.
REQ-039 irq_status=0x04, irq_clear=0x04 coincident with a new enabled edge on pin 2 -> status stays 0x04; clear alone next -> 0x00.
REQ-040 limit=100, rst_n asserted at count 50 then released, pad held 1 -> no pulse before 103 cycles after release, then one rise_pulse.
